// File: rtl/spi_cfg_pkg.sv
// ---------------------------------------------------------------------------
// spi_cfg_pkg
// Shared definitions for the SPI configuration sequencer:
//   - frame field widths (address, payload, readback)
//   - the sequencer state encoding
//   - the default configuration table, one {addr,data} word per entry
// ---------------------------------------------------------------------------
package spi_cfg_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int RDBK_W   = 24;
    localparam int MAX_REGS = 16;
    localparam int ENTRY_W  = ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Default power-up register image. Each word is {addr, data}, and
    // entries are issued in index order.
    function automatic logic [ENTRY_W-1:0] cfg_default_entry(input logic [3:0] idx);
        logic [ENTRY_W-1:0] entry;
        entry = '0;
        case (idx)
            4'd0:  entry = {4'h4, 16'hE6B6};
            4'd1:  entry = {4'h0, 16'h0001};
            4'd2:  entry = {4'h1, 16'h00A5};
            4'd3:  entry = {4'h2, 16'h1234};
            4'd4:  entry = {4'h3, 16'h8000};
            4'd5:  entry = {4'h5, 16'h0F0F};
            4'd6:  entry = {4'h6, 16'hC3C3};
            4'd7:  entry = {4'h7, 16'hFFFF};
            4'd8:  entry = {4'h8, 16'h0800};
            4'd9:  entry = {4'h9, 16'h0900};
            4'd10: entry = {4'hA, 16'h0A00};
            4'd11: entry = {4'hB, 16'h0B00};
            4'd12: entry = {4'hC, 16'h0C00};
            4'd13: entry = {4'hD, 16'h0D00};
            4'd14: entry = {4'hE, 16'h0E00};
            default: entry = {4'hF, 16'h0F00};
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/spi_cfg_sequencer_rom.sv
// ---------------------------------------------------------------------------
// spi_cfg_sequencer_rom
// Combinational lookup of the configuration table.
// Ports:
//   i_index  [3:0]   table entry to read
//   o_addr   [3:0]   register address of that entry
//   o_data   [15:0]  payload of that entry
// Entries at or beyond NUM_REGS read as zero.
// ---------------------------------------------------------------------------
module spi_cfg_sequencer_rom
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic [3:0]        i_index,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [ENTRY_W-1:0] w_entry;

    // Mask off entries the sequencer never issues so they read as zero.
    always_comb begin
        w_entry = '0;
        if (int'(i_index) < NUM_REGS) begin
            w_entry = cfg_default_entry(i_index);
        end
    end

    assign o_addr = w_entry[ENTRY_W-1:DATA_W];
    assign o_data = w_entry[DATA_W-1:0];

endmodule

// File: rtl/spi_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// spi_cfg_sequencer
// Upstream driver for spi_master: walks NUM_REGS {addr,data} table words,
// requests one SPI frame per word, waits for its acknowledge, leaves an
// idle gap between frames and reports completion, progress and timeouts.
// Ports:
//   i_sys_clk      system clock, rising edge
//   i_sys_rst_n    asynchronous active-low reset
//   i_start        level; a rising edge (re)starts a run from IDLE/DONE/ERROR
//   i_send_done    from spi_master; rising edge acknowledges the frame
//   i_data_out     from spi_master; readback captured on the acknowledge
//   o_addr         register address of the current frame
//   o_data_in      payload of the current frame
//   o_spi_send     frame request level
//   o_cfg_busy     run in progress
//   o_cfg_done     all frames acknowledged
//   o_cfg_err      a frame timed out
//   o_cfg_index    frame in flight / last acknowledged
//   o_last_rdbk    readback captured at the most recent acknowledge
// ---------------------------------------------------------------------------
module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REGS       = 8,
    parameter int START_DELAY    = 1000,
    parameter int GAP_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_start,
    input  logic              i_send_done,
    input  logic [RDBK_W-1:0] i_data_out,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data_in,
    output logic              o_spi_send,
    output logic              o_cfg_busy,
    output logic              o_cfg_done,
    output logic              o_cfg_err,
    output logic [3:0]        o_cfg_index,
    output logic [RDBK_W-1:0] o_last_rdbk
);

    localparam int DLY_W = (START_DELAY    > 1) ? $clog2(START_DELAY)    : 1;
    localparam int GAP_W = (GAP_CYCLES     > 1) ? $clog2(GAP_CYCLES)     : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_REGS - 1);

    state_t              r_state;
    state_t              w_next_state;

    logic                r_start_d;
    logic                r_done_d;
    logic                w_start_rise;
    logic                w_ack_rise;
    logic                w_restart;
    logic                w_advance;

    logic [DLY_W-1:0]    r_dly_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [TO_W-1:0]     r_to_cnt;

    logic [ADDR_W-1:0]   w_rom_addr;
    logic [DATA_W-1:0]   w_rom_data;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_spi_send;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [3:0]          r_index;
    logic [RDBK_W-1:0]   r_last_rdbk;

    spi_cfg_sequencer_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .i_index (r_index),
        .o_addr  (w_rom_addr),
        .o_data  (w_rom_data)
    );

    // Edge detection only: a level that is already high when a state is
    // entered is never mistaken for a fresh start or acknowledge.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_start_d <= 1'b0;
            r_done_d  <= 1'b0;
        end else begin
            r_start_d <= i_start;
            r_done_d  <= i_send_done;
        end
    end

    assign w_start_rise = i_start & ~r_start_d;
    assign w_ack_rise   = i_send_done & ~r_done_d;

    // Reset lands in PWR_WAIT so the device is configured without a start.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state <= ST_PWR_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. In WAIT_DONE the acknowledge is tested before the
    // timeout, so an ack on the expiry cycle still counts as success.
    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_next_state = ST_PWR_WAIT;
                    w_restart    = 1'b1;
                end
            end
            ST_PWR_WAIT: begin
                if (r_dly_cnt == DLY_LAST) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                w_next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_ack_rise) begin
                    w_next_state = ST_GAP;
                end else if (r_to_cnt == TO_LAST) begin
                    w_next_state = ST_ERROR;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (r_index == IDX_LAST) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_LOAD;
                        w_advance    = 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (w_start_rise) begin
                    w_next_state = ST_PWR_WAIT;
                    w_restart    = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Each counter runs only in its own state, is cleared everywhere else
    // and holds at its terminal value instead of wrapping.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_dly_cnt <= '0;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state != ST_PWR_WAIT) begin
                r_dly_cnt <= '0;
            end else if (r_dly_cnt != DLY_LAST) begin
                r_dly_cnt <= r_dly_cnt + 1'b1;
            end

            if (r_state != ST_GAP) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != GAP_LAST) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end

            if (r_state != ST_WAIT_DONE) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_LAST) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so that they are all low
    // while reset is held. addr/data latch in LOAD, one cycle before
    // spi_send rises, and then stay put until the next LOAD.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_addr      <= '0;
            r_data      <= '0;
            r_spi_send  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_index     <= '0;
            r_last_rdbk <= '0;
        end else begin
            r_spi_send <= (w_next_state == ST_WAIT_DONE);
            r_busy     <= (w_next_state inside {ST_PWR_WAIT, ST_LOAD, ST_SEND,
                                                ST_WAIT_DONE, ST_GAP});
            r_done     <= (w_next_state == ST_DONE);
            r_err      <= (w_next_state == ST_ERROR);

            if (r_state == ST_LOAD) begin
                r_addr <= w_rom_addr;
                r_data <= w_rom_data;
            end

            if (w_restart) begin
                r_index <= '0;
            end else if (w_advance) begin
                r_index <= r_index + 1'b1;
            end

            if (r_state == ST_WAIT_DONE && w_ack_rise) begin
                r_last_rdbk <= i_data_out;
            end
        end
    end

    assign o_addr      = r_addr;
    assign o_data_in   = r_data;
    assign o_spi_send  = r_spi_send;
    assign o_cfg_busy  = r_busy;
    assign o_cfg_done  = r_done;
    assign o_cfg_err   = r_err;
    assign o_cfg_index = r_index;
    assign o_last_rdbk = r_last_rdbk;

endmodule
